// File: rtl/amba3_apb_mem_slave_pkg.sv
// Shared types and helpers for the APB3 memory completer.
package amba3_apb_mem_slave_pkg;

  typedef enum logic {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_slv_state_e;

  typedef enum int unsigned {
    APB_WAIT_FIXED  = 0,
    APB_WAIT_RANDOM = 1
  } apb_wait_mode_e;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] APB_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] apb_lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? APB_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/amba3_apb_wait_gen.sv
// Wait-state generator: LFSR source, wait counter load/decrement and done flag.
module amba3_apb_wait_gen
  import amba3_apb_mem_slave_pkg::*;
#(
  parameter int unsigned WAIT_MODE = 0,
  parameter int unsigned WAIT_MAX  = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned CNT_BITS  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] wait_cfg_i,
  input  logic       load_i,   // setup edge: load a fresh wait count
  input  logic       dec_i,    // access edge still waiting
  input  logic       step_i,   // transfer completed: advance LFSR
  output logic       done_o    // wait count is zero after this edge
);

  localparam bit RandMode = (WAIT_MODE == APB_WAIT_RANDOM);

  logic [15:0]         lfsr_q, lfsr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, load_val;

  // Select the initial wait count for a new transfer
  always_comb begin
    load_val = '0;
    if (RandMode) begin
      load_val = CNT_BITS'(lfsr_q % 16'(WAIT_MAX + 1));
    end else if (32'(wait_cfg_i) > WAIT_MAX) begin
      load_val = CNT_BITS'(WAIT_MAX);
    end else begin
      load_val = CNT_BITS'(wait_cfg_i);
    end
  end

  // Next counter and LFSR state
  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (load_i) begin
      cnt_d = load_val;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (RandMode && step_i) begin
      lfsr_d = apb_lfsr_step(lfsr_q);
    end
    done_o = (cnt_d == '0);
  end

  // Counter and LFSR registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/amba3_apb_mem_slave.sv
// APB3 completer backed by a word-addressed RAM, with wait states and error counting.
module amba3_apb_mem_slave
  import amba3_apb_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WAIT_MODE = 0,
  parameter int unsigned WAIT_MAX  = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_BITS-1:0] paddr,
  input  logic [DATA_BITS-1:0] pwdata,
  output logic [DATA_BITS-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr,
  input  logic [3:0]           wait_cfg,
  output logic [15:0]          err_count
);

  localparam int unsigned DATA_BASE = $clog2(DATA_BITS / 8);
  localparam int unsigned IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS  = $clog2(WAIT_MAX + 2);
  localparam logic [ADDR_BITS-1:0] AlignMask = ADDR_BITS'((64'd1 << DATA_BASE) - 64'd1);

  logic [DATA_BITS-1:0] mem [DEPTH];

  apb_slv_state_e       state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic                 write_q, write_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATA_BITS-1:0] prdata_q, prdata_d;
  logic [15:0]          err_count_q, err_count_d;

  logic [ADDR_BITS-1:0] word_idx;
  logic [IDX_BITS-1:0]  idx_now;
  logic                 addr_err;
  logic                 wg_load, wg_dec, wg_step, wg_done;
  logic                 commit;

  assign word_idx = paddr >> DATA_BASE;
  assign idx_now  = word_idx[IDX_BITS-1:0];
  assign addr_err = (word_idx >= ADDR_BITS'(DEPTH)) || ((paddr & AlignMask) != '0);

  amba3_apb_wait_gen #(
    .WAIT_MODE (WAIT_MODE),
    .WAIT_MAX  (WAIT_MAX),
    .LFSR_SEED (LFSR_SEED),
    .CNT_BITS  (CNT_BITS)
  ) u_wait_gen (
    .clk_i      (pclk),
    .rst_i      (preset),
    .wait_cfg_i (wait_cfg),
    .load_i     (wg_load),
    .dec_i      (wg_dec),
    .step_i     (wg_step),
    .done_o     (wg_done)
  );

  // Transfer FSM; response outputs default to 0 so they only pulse in the completing cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    err_count_d = err_count_q;
    wg_load     = 1'b0;
    wg_dec      = 1'b0;
    wg_step     = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      APB_IDLE: begin
        if (psel && !penable) begin
          state_d   = APB_ACCESS;
          idx_d     = idx_now;
          write_d   = pwrite;
          err_d     = addr_err;
          wdata_d   = pwdata;
          wg_load   = 1'b1;
          pready_d  = wg_done;
          pslverr_d = wg_done && addr_err;
          if (wg_done && !pwrite && !addr_err) begin
            prdata_d = mem[idx_now];
          end
        end
      end
      APB_ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: no side effects
          state_d = APB_IDLE;
        end else if (penable && pready_q) begin
          state_d = APB_IDLE;
          wg_step = 1'b1;
          commit  = write_q && !err_q;
          if (err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
        end else if (penable) begin
          wg_dec    = 1'b1;
          pready_d  = wg_done;
          pslverr_d = wg_done && err_q;
          if (wg_done && !write_q && !err_q) begin
            prdata_d = mem[idx_q];
          end
        end else begin
          // penable dropped mid-access: hold the response as-is
          pready_d  = pready_q;
          pslverr_d = pslverr_q;
          prdata_d  = prdata_q;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= APB_IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge pclk) begin
    if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign err_count = err_count_q;

endmodule
